bsg_chip_noc_wide_link_serdes: RTL

//  Bidirectional width converter between a manycore wide link (fwd or rev packet,

---
 rtl/bsg_chip_noc_wide_link_serdes_pkg.sv | 14 +
 rtl/bsg_chip_noc_flit_assembler.sv | 65 ++++++
 rtl/bsg_chip_noc_wide_link_serdes.sv | 92 +++++++++
 3 files changed

// File: rtl/bsg_chip_noc_wide_link_serdes_pkg.sv
// Shared sizing helpers for the wide<->narrow link serdes.
// Flit count and counter width are derived here so TX and RX always agree.
package bsg_chip_noc_wide_link_serdes_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // A counter for a single element still needs one bit to exist.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_chip_noc_flit_assembler.sv
// RX half: collects els_lp narrow flits (LSB first) into one wide packet, 1 cycle flit-to-packet.
// Holds the finished packet until drained; refuses flits only while full and not draining.
module bsg_chip_noc_flit_assembler
  import bsg_chip_noc_wide_link_serdes_pkg::*;
#(
  parameter int wide_width_p   = 80,
  parameter int narrow_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      narrow_v_i,
  input  logic [narrow_width_p-1:0] narrow_data_i,
  output logic                      narrow_yumi_o,
  output logic                      wide_v_o,
  output logic [wide_width_p-1:0]   wide_data_o,
  input  logic                      wide_ready_and_i
);

  localparam int els_lp       = ceil_div(wide_width_p, narrow_width_p);
  localparam int cnt_width_lp = safe_clog2(els_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(els_lp - 1);

  logic                    rx_full;
  logic [cnt_width_lp-1:0] rx_cnt;
  logic [wide_width_p-1:0] rx_data;
  logic                    rx_last;
  logic                    rx_drain;

  assign rx_last       = (rx_cnt == last_cnt_lp);
  assign rx_drain      = rx_full & wide_ready_and_i;
  assign narrow_yumi_o = reset_n_i & narrow_v_i & (~rx_full | wide_ready_and_i);
  assign wide_v_o      = rx_full;
  assign wide_data_o   = rx_data;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_full <= 1'b0;
      rx_cnt  <= '0;
    end else begin
      if (narrow_yumi_o) begin
        rx_cnt <= rx_last ? '0 : rx_cnt + cnt_width_lp'(1);
      end
      // A last flit landing on the drain cycle keeps the register full.
      if (narrow_yumi_o && rx_last) begin
        rx_full <= 1'b1;
      end else if (rx_drain) begin
        rx_full <= 1'b0;
      end
    end
  end

  // Only bits inside the wide packet are stored; the pad of the top flit is dropped here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_data <= '0;
    end else if (narrow_yumi_o) begin
      for (int b = 0; b < wide_width_p; b++) begin
        if (rx_cnt == cnt_width_lp'(b / narrow_width_p)) begin
          rx_data[b] <= narrow_data_i[b % narrow_width_p];
        end
      end
    end
  end

endmodule

// File: rtl/bsg_chip_noc_wide_link_serdes.sv
// Wide<->narrow link serdes: TX splits wide packets into flits LSB first, RX reassembles.
// First flit 1 cycle after accept, 1 flit/cycle; TX stalls on yumi, RX stalls on wide ready.
module bsg_chip_noc_wide_link_serdes
  import bsg_chip_noc_wide_link_serdes_pkg::*;
#(
  parameter int wide_width_p   = 80,
  parameter int narrow_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      wide_v_i,
  input  logic [wide_width_p-1:0]   wide_data_i,
  output logic                      wide_ready_and_o,
  output logic                      narrow_v_o,
  output logic [narrow_width_p-1:0] narrow_data_o,
  input  logic                      narrow_yumi_i,
  input  logic                      narrow_v_i,
  input  logic [narrow_width_p-1:0] narrow_data_i,
  output logic                      narrow_yumi_o,
  output logic                      wide_v_o,
  output logic [wide_width_p-1:0]   wide_data_o,
  input  logic                      wide_ready_and_i
);

  localparam int els_lp       = ceil_div(wide_width_p, narrow_width_p);
  localparam int cnt_width_lp = safe_clog2(els_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(els_lp - 1);

  logic                    tx_full;
  logic [cnt_width_lp-1:0] tx_cnt;
  logic [wide_width_p-1:0] tx_data;
  logic                    tx_last;
  logic                    tx_accept;
  logic                    tx_advance;

  assign tx_last    = (tx_cnt == last_cnt_lp);
  assign tx_advance = narrow_yumi_i & tx_full;
  // Ready also on the cycle the last flit leaves, so packets stream back to back.
  assign wide_ready_and_o = reset_n_i & (~tx_full | (narrow_yumi_i & tx_last));
  assign tx_accept  = wide_v_i & wide_ready_and_o;
  assign narrow_v_o = tx_full;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_full <= 1'b0;
      tx_cnt  <= '0;
      tx_data <= '0;
    end else if (tx_accept) begin
      tx_full <= 1'b1;
      tx_cnt  <= '0;
      tx_data <= wide_data_i;
    end else if (tx_advance) begin
      if (tx_last) begin
        tx_full <= 1'b0;
        tx_cnt  <= '0;
      end else begin
        tx_cnt  <= tx_cnt + cnt_width_lp'(1);
      end
    end
  end

  // Bits beyond the wide packet never get selected, which zero-pads the top flit.
  always_comb begin
    narrow_data_o = '0;
    for (int b = 0; b < wide_width_p; b++) begin
      if (tx_cnt == cnt_width_lp'(b / narrow_width_p)) begin
        narrow_data_o[b % narrow_width_p] = tx_data[b];
      end
    end
  end

  bsg_chip_noc_flit_assembler #(
    .wide_width_p  (wide_width_p),
    .narrow_width_p(narrow_width_p)
  ) rx (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .narrow_v_i      (narrow_v_i),
    .narrow_data_i   (narrow_data_i),
    .narrow_yumi_o   (narrow_yumi_o),
    .wide_v_o        (wide_v_o),
    .wide_data_o     (wide_data_o),
    .wide_ready_and_i(wide_ready_and_i)
  );

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    narrow_yumi_i |-> narrow_v_o);

  handshake_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !$isunknown({wide_v_i, narrow_v_i, narrow_yumi_i, wide_ready_and_i}));

endmodule
